// File: rtl/gray_arb_pkg.sv
// Shared definitions for the round-robin binary-to-Gray conversion arbiter.
//   state_t   : FSM state encoding (IDLE, CONV, HOLD)
//   N_REQ_DEF : default number of requesters
//   WIDTH_DEF : default operand / result width
package gray_arb_pkg;

    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray converter.
//   bin    : binary operand
//   gray_c : Gray-coded result, bin ^ (bin >> 1)
module bin2gray #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray_c
);

    assign gray_c = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-Gray converter among N_REQ requesters.
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   req       : per-requester level request, held until granted
//   bin_in    : packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt       : one-hot combinational grant, only in IDLE
//   gray_out  : registered Gray result
//   gray_id   : registered index of the requester owning gray_out
//   out_valid : result valid, held until out_ready handshake
//   out_ready : consumer acceptance
//   busy      : high whenever the FSM is not IDLE
module gray_conv_arbiter
    import gray_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     bin_in,
    output logic [N_REQ-1:0]           gnt,
    output logic [WIDTH-1:0]           gray_out,
    output logic [$clog2(N_REQ)-1:0]   gray_id,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy
);

    localparam int unsigned ID_W = $clog2(N_REQ);
    localparam int unsigned CW   = ID_W + 1;

    state_t            state, state_d;
    logic [ID_W-1:0]   ptr, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   gray_id_d;
    logic [ID_W-1:0]   win;
    logic [ID_W-1:0]   ptr_nxt;
    logic [WIDTH-1:0]  op_q, op_d;
    logic [WIDTH-1:0]  op_sel;
    logic [WIDTH-1:0]  gray_d;
    logic [WIDTH-1:0]  gray_c;
    logic              out_valid_d;
    logic              found;

    // Round-robin search: first set request at or above ptr, wrapping modulo N_REQ.
    always_comb begin
        logic [CW-1:0] cand;
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + CW'(i);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (!found && req[cand[ID_W-1:0]]) begin
                found = 1'b1;
                win   = cand[ID_W-1:0];
            end
        end
    end

    // Pointer advances just past the winner.
    always_comb begin
        logic [CW-1:0] nxt;
        nxt = {1'b0, win} + CW'(1);
        if (nxt >= CW'(N_REQ)) begin
            nxt = '0;
        end
        ptr_nxt = nxt[ID_W-1:0];
    end

    // Winner's operand mux.
    always_comb begin
        op_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win == ID_W'(i)) begin
                op_sel = bin_in[i*WIDTH +: WIDTH];
            end
        end
    end

    bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin    (op_q),
        .gray_c (gray_c)
    );

    // Next-state and output decode.
    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        op_d        = op_q;
        id_d        = id_q;
        gray_d      = gray_out;
        gray_id_d   = gray_id;
        out_valid_d = out_valid;
        gnt         = '0;
        busy        = (state != IDLE);

        case (state)
            IDLE: begin
                if (found) begin
                    // Gated so gnt reads zero while reset is held with req set.
                    if (!rst) begin
                        gnt[win] = 1'b1;
                    end
                    state_d = CONV;
                    ptr_d   = ptr_nxt;
                    op_d    = op_sel;
                    id_d    = win;
                end
            end
            CONV: begin
                gray_d      = gray_c;
                gray_id_d   = id_q;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            op_q      <= '0;
            id_q      <= '0;
            gray_out  <= '0;
            gray_id   <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            op_q      <= op_d;
            id_q      <= id_d;
            gray_out  <= gray_d;
            gray_id   <= gray_id_d;
            out_valid <= out_valid_d;
        end
    end

endmodule
